// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed receiver: PID codes, FSM states,
// bit-timing constants and CRC constants. The CRC constants are only consumed
// when USB_RX_CRC_CHECK_EN is defined.
package usb_pkg;

    // PID codes (low nibble of the PID byte)
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // Bit timing: 100 MHz / 12 MHz = 8.33 clk, approximated by 8, 8, 9
    localparam logic [3:0] SAMPLE_OFFSET = 4'd4;
    localparam logic [3:0] PERIOD_SHORT  = 4'd8;
    localparam logic [3:0] PERIOD_LONG   = 4'd9;

    // Byte limits: 64 payload bytes plus 2 CRC bytes; buffer holds 64 bytes
    localparam logic [6:0] MAX_PKT_BYTES = 7'd66;
    localparam logic [6:0] BUFFER_FULL   = 7'd64;

    // CRC generators and good-packet residuals (shift-left form)
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_PAYLOAD,
        ST_EOP_WAIT,
        ST_ERR_WAIT
    } rx_state_t;

    typedef enum logic [1:0] {
        PK_TOKEN,
        PK_DATA,
        PK_HANDSHAKE,
        PK_BAD
    } pid_class_t;

    function automatic pid_class_t classify_pid(input logic [3:0] pid);
        pid_class_t cls;
        case (pid)
            PID_OUT, PID_IN:             cls = PK_TOKEN;
            PID_DATA0, PID_DATA1:        cls = PK_DATA;
            PID_ACK, PID_NAK, PID_STALL: cls = PK_HANDSHAKE;
            default:                     cls = PK_BAD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/usb_rx_bit_decoder.sv
// Line front end: synchronizes D+/D-, recovers bit timing from D+ edges,
// NRZI-decodes and removes stuffed zeros. All outputs are one-cycle strobes
// registered one clock after the sample point.
module usb_rx_bit_decoder
    import usb_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic dplus_in,
    input  logic dminus_in,
    input  logic unstuff_en,
    output logic bit_strobe,
    output logic bit_value,
    output logic se0,
    output logic stuff_err
);

    logic       dp_s1, dp_s2, dm_s1, dm_s2, dp_prev;
    logic [3:0] cnt;
    logic [1:0] pat_idx;
    logic [3:0] period;
    logic       edge_det, sample;
    logic       prev_level;
    logic [2:0] ones_cnt;
    logic       line_se0, dec_bit;

    // Two-flop synchronizer plus a delayed copy of D+ for edge detection
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            dp_s1   <= 1'b1;
            dp_s2   <= 1'b1;
            dp_prev <= 1'b1;
            dm_s1   <= 1'b0;
            dm_s2   <= 1'b0;
        end else begin
            dp_s1   <= dplus_in;
            dp_s2   <= dp_s1;
            dp_prev <= dp_s2;
            dm_s1   <= dminus_in;
            dm_s2   <= dm_s1;
        end
    end

    // The edge cycle is count 0 of a new period; sample mid-bit
    assign edge_det = dp_s2 ^ dp_prev;
    assign period   = (pat_idx == 2'd2) ? PERIOD_LONG : PERIOD_SHORT;
    assign sample   = !edge_det && (cnt == SAMPLE_OFFSET);
    assign line_se0 = !dp_s2 && !dm_s2;
    assign dec_bit  = (dp_s2 == prev_level);

    // Bit timer: free-running 8/8/9 pattern, restarted on every D+ edge
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt     <= 4'd0;
            pat_idx <= 2'd0;
        end else if (edge_det) begin
            cnt     <= 4'd1;
            pat_idx <= 2'd0;
        end else if (cnt == period - 4'd1) begin
            cnt     <= 4'd0;
            pat_idx <= (pat_idx == 2'd2) ? 2'd0 : pat_idx + 2'd1;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    // NRZI decode and unstuff at each sample point; SE0 restores the J
    // reference so the idle J after EOP decodes as 1
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            bit_strobe <= 1'b0;
            bit_value  <= 1'b0;
            se0        <= 1'b0;
            stuff_err  <= 1'b0;
            prev_level <= 1'b1;
            ones_cnt   <= 3'd0;
        end else begin
            bit_strobe <= 1'b0;
            bit_value  <= 1'b0;
            se0        <= 1'b0;
            stuff_err  <= 1'b0;
            if (sample) begin
                if (line_se0) begin
                    bit_strobe <= 1'b1;
                    se0        <= 1'b1;
                    prev_level <= 1'b1;
                    ones_cnt   <= 3'd0;
                end else begin
                    prev_level <= dp_s2;
                    if (!unstuff_en) begin
                        bit_strobe <= 1'b1;
                        bit_value  <= dec_bit;
                        ones_cnt   <= 3'd0;
                    end else if (ones_cnt == 3'd6) begin
                        // stuffed position: a 0 is dropped, a 1 is an error
                        ones_cnt  <= 3'd0;
                        stuff_err <= dec_bit;
                    end else begin
                        bit_strobe <= 1'b1;
                        bit_value  <= dec_bit;
                        ones_cnt   <= dec_bit ? ones_cnt + 3'd1 : 3'd0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/usb_rx.sv
// USB full-speed packet receiver. Validates SYNC/PID/EOP, forwards DATA0/DATA1
// payload bytes through a two-byte delay line so CRC bytes never reach the
// buffer, and reports packet type and status.
// Optional CRC5/CRC16 checking is compiled in with USB_RX_CRC_CHECK_EN.
module usb_rx
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    input  logic [6:0] buffer_occupancy,
    output logic [7:0] rx_packet_data,
    output logic       store_rx_packet_data,
    output logic       flush,
    output logic       rx_error,
    output logic       rx_transfer_active,
    output logic       rx_data_ready,
    output logic [3:0] rx_packet
);

    // Decoder strobes: bit_strobe is valid for one cycle, carrying bit_value
    // or an SE0 marker; stuff_err is a separate one-cycle strobe.
    logic       bit_strobe, bit_value, se0, stuff_err, unstuff_en;
    rx_state_t  state, state_n;
    logic [2:0] bit_cnt;
    logic [6:0] sreg;
    logic [7:0] byte_in;
    logic [3:0] pid;
    pid_class_t pid_cls, new_cls;
    logic [6:0] byte_cnt;
    logic [7:0] dly0, dly1;
    logic [1:0] dly_cnt;
    logic       se0_seen;
    logic       len_ok, crc_ok;
    logic       ev_err, ev_sync_ok, ev_pid_ok, ev_byte, ev_eop_ok, do_store;

    assign unstuff_en = (state == ST_SYNC) || (state == ST_PID) ||
                        (state == ST_PAYLOAD) || (state == ST_EOP_WAIT);

    usb_rx_bit_decoder u_dec (
        .clk        (clk),
        .n_rst      (n_rst),
        .dplus_in   (dplus_in),
        .dminus_in  (dminus_in),
        .unstuff_en (unstuff_en),
        .bit_strobe (bit_strobe),
        .bit_value  (bit_value),
        .se0        (se0),
        .stuff_err  (stuff_err)
    );

    // Byte being completed if the current strobe is its last bit (LSB first)
    assign byte_in = {bit_value, sreg};
    assign new_cls = classify_pid(byte_in[3:0]);
    assign pid_cls = classify_pid(pid);
    assign len_ok  = (pid_cls == PK_TOKEN) ? (byte_cnt == 7'd2) : (byte_cnt >= 7'd2);

`ifdef USB_RX_CRC_CHECK_EN
    logic [15:0] crc16;
    logic [4:0]  crc5;
    logic        fb16, fb5;

    assign fb16   = crc16[15] ^ bit_value;
    assign fb5    = crc5[4] ^ bit_value;
    assign crc_ok = (pid_cls == PK_TOKEN) ? (crc5 == CRC5_RESIDUAL) : (crc16 == CRC16_RESIDUAL);

    // Serial CRCs over every field after the PID, including the CRC itself
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            crc16 <= 16'hFFFF;
            crc5  <= 5'h1F;
        end else if (ev_pid_ok) begin
            crc16 <= 16'hFFFF;
            crc5  <= 5'h1F;
        end else if (state == ST_PAYLOAD && bit_strobe && !se0) begin
            crc16 <= {crc16[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'h0000);
            crc5  <= {crc5[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'h00);
        end
    end
`else
    assign crc_ok = 1'b1;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next state and per-strobe events; errors and EOP override other moves
    always_comb begin
        state_n    = state;
        ev_err     = 1'b0;
        ev_sync_ok = 1'b0;
        ev_pid_ok  = 1'b0;
        ev_byte    = 1'b0;
        ev_eop_ok  = 1'b0;
        do_store   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bit_strobe && !se0 && !bit_value) state_n = ST_SYNC;
            end
            ST_SYNC: begin
                if (stuff_err || (bit_strobe && (se0 || (bit_value != (bit_cnt == 3'd7))))) begin
                    ev_err = 1'b1;
                end else if (bit_strobe && bit_cnt == 3'd7) begin
                    ev_sync_ok = 1'b1;
                    state_n    = ST_PID;
                end
            end
            ST_PID: begin
                if (stuff_err || (bit_strobe && se0)) begin
                    ev_err = 1'b1;
                end else if (bit_strobe && bit_cnt == 3'd7) begin
                    if ((byte_in[7:4] != ~byte_in[3:0]) || (new_cls == PK_BAD)) begin
                        ev_err = 1'b1;
                    end else begin
                        ev_pid_ok = 1'b1;
                        state_n   = (new_cls == PK_HANDSHAKE) ? ST_EOP_WAIT : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (stuff_err) begin
                    ev_err = 1'b1;
                end else if (bit_strobe && se0) begin
                    if (bit_cnt != 3'd0 || !len_ok || !crc_ok) ev_err = 1'b1;
                    else                                        ev_eop_ok = 1'b1;
                end else if (bit_strobe && bit_cnt == 3'd7) begin
                    ev_byte = 1'b1;
                    if (byte_cnt == MAX_PKT_BYTES) begin
                        ev_err = 1'b1;
                    end else if (pid_cls == PK_DATA && dly_cnt == 2'd2) begin
                        if (buffer_occupancy >= BUFFER_FULL) ev_err   = 1'b1;
                        else                                 do_store = 1'b1;
                    end
                end
            end
            ST_EOP_WAIT: begin
                if (stuff_err || (bit_strobe && !se0)) ev_err    = 1'b1;
                else if (bit_strobe)                   ev_eop_ok = 1'b1;
            end
            ST_ERR_WAIT: begin
                if (bit_strobe && se0_seen && !se0) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (ev_err)    state_n = ST_ERR_WAIT;
        if (ev_eop_ok) state_n = ST_IDLE;
    end

    // Datapath, delay line and registered outputs
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sreg                 <= 7'd0;
            bit_cnt              <= 3'd0;
            pid                  <= 4'd0;
            byte_cnt             <= 7'd0;
            dly0                 <= 8'd0;
            dly1                 <= 8'd0;
            dly_cnt              <= 2'd0;
            se0_seen             <= 1'b0;
            rx_packet_data       <= 8'd0;
            store_rx_packet_data <= 1'b0;
            flush                <= 1'b0;
            rx_error             <= 1'b0;
            rx_transfer_active   <= 1'b0;
            rx_data_ready        <= 1'b0;
            rx_packet            <= 4'd0;
        end else begin
            store_rx_packet_data <= 1'b0;
            flush                <= 1'b0;
            rx_data_ready        <= 1'b0;

            if (bit_strobe && !se0) sreg <= byte_in[7:1];

            if (ev_err || ev_eop_ok)    bit_cnt <= 3'd0;
            else if (state == ST_IDLE)  bit_cnt <= (state_n == ST_SYNC) ? 3'd1 : 3'd0;
            else if (bit_strobe && !se0) bit_cnt <= bit_cnt + 3'd1;

            if (ev_err)
                se0_seen <= bit_strobe && se0;
            else if (state == ST_ERR_WAIT && bit_strobe && se0)
                se0_seen <= 1'b1;

            if (ev_sync_ok) begin
                rx_error           <= 1'b0;
                rx_transfer_active <= 1'b1;
            end
            if (ev_err) begin
                rx_error           <= 1'b1;
                rx_transfer_active <= 1'b0;
            end

            if (ev_pid_ok) begin
                pid      <= byte_in[3:0];
                byte_cnt <= 7'd0;
                dly_cnt  <= 2'd0;
                flush    <= (new_cls == PK_DATA) && (buffer_occupancy != 7'd0);
            end

            if (ev_byte && !ev_err) begin
                byte_cnt <= byte_cnt + 7'd1;
                if (pid_cls == PK_DATA) begin
                    dly0    <= dly1;
                    dly1    <= byte_in;
                    dly_cnt <= (dly_cnt == 2'd2) ? 2'd2 : dly_cnt + 2'd1;
                end
            end

            if (do_store) begin
                store_rx_packet_data <= 1'b1;
                rx_packet_data       <= dly0;
            end

            if (ev_eop_ok) begin
                rx_packet          <= pid;
                rx_data_ready      <= (pid_cls == PK_DATA);
                rx_transfer_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx.sv
// Self-checking bench for usb_rx: builds NRZI/bit-stuffed packets on D+/D-,
// scoreboards the stored payload bytes and checks per-packet status.
module tb_usb_rx;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       dplus_in = 1'b1;
    logic       dminus_in = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data, flush, rx_error, rx_transfer_active, rx_data_ready;
    logic [3:0] rx_packet;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic       bit_q[$];
    int         flush_cnt, ready_cnt, store_cnt;
    logic       active_seen;
    int         tb_pat = 0;
    int         ones = 0;
    logic       nrzi_lvl = 1'b1;
    logic [15:0] crc16;

    // Clock and DUT
    always #5 clk = ~clk;

    usb_rx dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .dplus_in             (dplus_in),
        .dminus_in            (dminus_in),
        .buffer_occupancy     (buffer_occupancy),
        .rx_packet_data       (rx_packet_data),
        .store_rx_packet_data (store_rx_packet_data),
        .flush                (flush),
        .rx_error             (rx_error),
        .rx_transfer_active   (rx_transfer_active),
        .rx_data_ready        (rx_data_ready),
        .rx_packet            (rx_packet)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: scoreboard stores, count pulses
    always @(negedge clk) begin
        if (n_rst) begin
            if (store_rx_packet_data) begin
                store_cnt++;
                if (exp_q.size() != 0) check("store_data", {24'h0, rx_packet_data}, {24'h0, exp_q.pop_front()});
            end
            if (flush) flush_cnt++;
            if (rx_data_ready) ready_cnt++;
            if (rx_transfer_active) active_seen = 1'b1;
        end
    end

    // Watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Line driver: one bit time with the 8/8/9 pattern
    task automatic hold_level(input logic dp, input logic dm);
        int n;
        dplus_in  = dp;
        dminus_in = dm;
        n = (tb_pat == 2) ? 9 : 8;
        tb_pat = (tb_pat == 2) ? 0 : tb_pat + 1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_nrzi_bit(input logic b);
        if (!b) nrzi_lvl = ~nrzi_lvl;
        hold_level(nrzi_lvl, ~nrzi_lvl);
    endtask

    task automatic send_stuffed(input logic b, input bit omit);
        send_nrzi_bit(b);
        if (b) ones++;
        else   ones = 0;
        if (ones == 6) begin
            ones = 0;
            if (!omit) send_nrzi_bit(1'b0);
        end
    endtask

    task automatic send_packet(input bit omit);
        ones = 0;
        for (int i = 0; i < 8; i++) send_stuffed(i == 7, omit);
        foreach (bit_q[i]) send_stuffed(bit_q[i], omit);
        hold_level(1'b0, 1'b0);
        hold_level(1'b0, 1'b0);
        nrzi_lvl = 1'b1;
        repeat (5) hold_level(1'b1, 1'b0);
        bit_q.delete();
    endtask

    // Packet builders
    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
    endtask

    task automatic push_pid(input logic [3:0] p);
        push_byte({~p, p});
        crc16 = 16'hFFFF;
    endtask

    task automatic push_data(input logic [7:0] b, input bit keep);
        logic fb;
        push_byte(b);
        for (int i = 0; i < 8; i++) begin
            fb = crc16[15] ^ b[i];
            crc16 = {crc16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        if (keep) exp_q.push_back(b);
    endtask

    task automatic push_crc16();
        logic [15:0] c;
        c = ~crc16;
        for (int i = 0; i < 16; i++) bit_q.push_back(c[15-i]);
    endtask

    task automatic push_token_body(input logic [10:0] f);
        logic [4:0] c5;
        logic fb;
        c5 = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            bit_q.push_back(f[i]);
            fb = c5[4] ^ f[i];
            c5 = {c5[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        c5 = ~c5;
        for (int i = 0; i < 5; i++) bit_q.push_back(c5[4-i]);
    endtask

    // Send the built packet and check its outcome
    task automatic run_pkt(input string name, input bit omit, input int exp_flush,
                           input int exp_ready, input logic exp_err, input logic [3:0] exp_pid);
        int n_exp;
        n_exp = exp_q.size();
        flush_cnt = 0; ready_cnt = 0; store_cnt = 0; active_seen = 1'b0;
        send_packet(omit);
        check({name, "_stores"}, store_cnt, n_exp);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_flush"}, flush_cnt, exp_flush);
        check({name, "_ready"}, ready_cnt, exp_ready);
        check({name, "_error"}, {31'h0, rx_error}, {31'h0, exp_err});
        check({name, "_pid"}, {28'h0, rx_packet}, {28'h0, exp_pid});
        check({name, "_active_seen"}, {31'h0, active_seen}, 32'h1);
        check({name, "_active_after"}, {31'h0, rx_transfer_active}, 32'h0);
        exp_q.delete();
    endtask

    initial begin
        logic [6:0] occ;
        // Reset
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", {24'h0, rx_packet_data}, 32'h0);
        check("rst_store", {31'h0, store_rx_packet_data}, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_error", {31'h0, rx_error}, 32'h0);
        check("rst_active", {31'h0, rx_transfer_active}, 32'h0);
        check("rst_ready", {31'h0, rx_data_ready}, 32'h0);
        check("rst_pid", {28'h0, rx_packet}, 32'h0);
        n_rst = 1'b1;
        repeat (6) hold_level(1'b1, 1'b0);

        // ACK handshake
        push_pid(4'b0010);
        run_pkt("ack", 0, 0, 0, 1'b0, 4'b0010);

        // DATA0, empty buffer
        buffer_occupancy = 7'd0;
        push_pid(4'b0011); push_data(8'h00, 1); push_data(8'h01, 1); push_crc16();
        run_pkt("data0", 0, 0, 1, 1'b0, 4'b0011);

        // DATA1, occupied buffer
        buffer_occupancy = 7'd5;
        push_pid(4'b1011); push_data(8'h00, 1); push_data(8'h01, 1); push_data(8'h02, 1); push_crc16();
        run_pkt("data1", 0, 1, 1, 1'b0, 4'b1011);

        // Stuffed all-ones payload
        buffer_occupancy = 7'd0;
        push_pid(4'b0011); push_data(8'hFF, 1); push_data(8'hFF, 1); push_crc16();
        run_pkt("stuff_ok", 0, 0, 1, 1'b0, 4'b0011);

        // Same payload with stuff bits omitted
        push_pid(4'b0011); push_data(8'hFF, 0); push_data(8'hFF, 0); push_crc16();
        run_pkt("stuff_err", 1, 0, 0, 1'b1, 4'b0011);

        // Bad PID complement, then a good ACK clears the error
        push_byte(8'h33);
        run_pkt("bad_pid", 0, 0, 0, 1'b1, 4'b0011);
        push_pid(4'b0010);
        run_pkt("ack_clear", 0, 0, 0, 1'b0, 4'b0010);

        // OUT token: no store, no flush even with bytes in the buffer
        buffer_occupancy = 7'd5;
        push_pid(4'b0001); push_token_body(11'h3A5);
        run_pkt("token", 0, 0, 0, 1'b0, 4'b0001);

        // Full 64-byte DATA0 with random payload and occupancy
        occ = 7'($urandom_range(1, 63));
        buffer_occupancy = occ;
        push_pid(4'b0011);
        for (int i = 0; i < 64; i++) push_data(8'($urandom_range(0, 255)), 1);
        push_crc16();
        run_pkt("max64", 0, 1, 0 + 1, 1'b0, 4'b0011);

        // 65 payload bytes: the first 64 are stored, then overflow error
        buffer_occupancy = 7'd0;
        push_pid(4'b1011);
        for (int i = 0; i < 65; i++) push_data(8'($urandom_range(0, 255)), i < 64);
        push_crc16();
        run_pkt("overflow", 0, 0, 0, 1'b1, 4'b0011);

        // Store attempted into a full buffer
        buffer_occupancy = 7'd64;
        push_pid(4'b0011); push_data(8'h5A, 0); push_crc16();
        run_pkt("buf_full", 0, 1, 0, 1'b1, 4'b0011);

        // EOP three bits past a byte boundary
        buffer_occupancy = 7'd0;
        push_pid(4'b1011); push_data(8'h00, 1); push_data(8'h01, 1); push_crc16();
        bit_q.push_back(1'b1); bit_q.push_back(1'b0); bit_q.push_back(1'b1);
        run_pkt("eop_off", 0, 0, 0, 1'b1, 4'b0011);

        // Recovery with NAK
        push_pid(4'b1010);
        run_pkt("nak", 0, 0, 0, 1'b0, 4'b1010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
